// File: rtl/chip8_mem_pkg.sv
// Shared constants for the CHIP-8 memory arbiter: default widths, FSM state
// encoding, requester IDs and the round-robin `last` encoding.
package chip8_mem_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_LD_WR = 3'd1;
    localparam state_t S_D_WR  = 3'd2;
    localparam state_t S_D_RD  = 3'd3;
    localparam state_t S_D_CAP = 3'd4;
    localparam state_t S_F_HI  = 3'd5;
    localparam state_t S_F_LO  = 3'd6;
    localparam state_t S_F_CAP = 3'd7;

    // Requester IDs double as bit positions in the one-hot winner vector.
    localparam logic [1:0] REQ_LD    = 2'd0;
    localparam logic [1:0] REQ_DAT   = 2'd1;
    localparam logic [1:0] REQ_FETCH = 2'd2;

    localparam logic LAST_DAT   = 1'b0;
    localparam logic LAST_FETCH = 1'b1;

endpackage

// File: rtl/chip8_rr_pick.sv
// Two-way round-robin between fetch and data with a fixed-priority loader
// override; holds the `last` bit and reports the one-hot winner.
module chip8_rr_pick
    import chip8_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_ld,
    input  logic       i_dat,
    input  logic       i_fetch,
    output logic [2:0] o_win,
    output logic       o_last_nxt
);

    logic r_last;

    // Fetch takes a tie when data was served last (the reset value).
    always_comb begin
        o_win      = 3'b000;
        o_last_nxt = r_last;
        if (i_ld) begin
            o_win[REQ_LD] = 1'b1;
        end else if (i_fetch && (!i_dat || r_last == LAST_DAT)) begin
            o_win[REQ_FETCH] = 1'b1;
            o_last_nxt       = LAST_FETCH;
        end else if (i_dat) begin
            o_win[REQ_DAT] = 1'b1;
            o_last_nxt     = LAST_DAT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= LAST_DAT;
        end else if (i_en) begin
            r_last <= o_last_nxt;
        end
    end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Sequences loader writes, CPU data accesses and 16-bit opcode fetches onto a
// single-port synchronous-read memory; every output is a flop.
module chip8_mem_arbiter
    import chip8_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ld_req,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [DATA_W-1:0]     ld_wdata,
    output logic                  ld_gnt,

    input  logic                  dat_req,
    input  logic                  dat_we,
    input  logic [ADDR_W-1:0]     dat_addr,
    input  logic [DATA_W-1:0]     dat_wdata,
    output logic                  dat_gnt,
    output logic                  dat_valid,
    output logic [DATA_W-1:0]     dat_rdata,

    input  logic                  fetch_req,
    input  logic [ADDR_W-1:0]     fetch_addr,
    output logic                  fetch_gnt,
    output logic                  fetch_valid,
    output logic [2*DATA_W-1:0]   fetch_data,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    state_t              r_state;
    logic [DATA_W-1:0]   r_hi;
    logic [2:0]          w_win;
    logic                w_last_nxt;
    logic                w_idle;

    assign w_idle = (r_state == S_IDLE);

    chip8_rr_pick u_pick (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_idle),
        .i_ld       (ld_req),
        .i_dat      (dat_req),
        .i_fetch    (fetch_req),
        .o_win      (w_win),
        .o_last_nxt (w_last_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hi        <= '0;
            ld_gnt      <= 1'b0;
            dat_gnt     <= 1'b0;
            dat_valid   <= 1'b0;
            dat_rdata   <= '0;
            fetch_gnt   <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            ld_gnt      <= 1'b0;
            dat_gnt     <= 1'b0;
            dat_valid   <= 1'b0;
            fetch_gnt   <= 1'b0;
            fetch_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (w_win[REQ_LD]) begin
                        r_state   <= S_LD_WR;
                        ld_gnt    <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= ld_addr;
                        mem_wdata <= ld_wdata;
                    end else if (w_win[REQ_FETCH] || w_win[REQ_DAT]) begin
                        // The updated `last` names whichever of fetch/data just won.
                        if (w_last_nxt == LAST_FETCH) begin
                            r_state   <= S_F_HI;
                            fetch_gnt <= 1'b1;
                            mem_en    <= 1'b1;
                            mem_addr  <= fetch_addr;
                        end else begin
                            r_state  <= dat_we ? S_D_WR : S_D_RD;
                            dat_gnt  <= 1'b1;
                            mem_en   <= 1'b1;
                            mem_we   <= dat_we;
                            mem_addr <= dat_addr;
                            if (dat_we) begin
                                mem_wdata <= dat_wdata;
                            end
                        end
                    end
                end
                S_LD_WR, S_D_WR: begin
                    r_state <= S_IDLE;
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                end
                S_D_RD: begin
                    r_state <= S_D_CAP;
                    mem_en  <= 1'b0;
                end
                S_D_CAP: begin
                    r_state   <= S_IDLE;
                    dat_rdata <= mem_rdata;
                    dat_valid <= 1'b1;
                end
                S_F_HI: begin
                    // Low byte address wraps naturally at the top of memory.
                    r_state  <= S_F_LO;
                    mem_addr <= mem_addr + ADDR_W'(1);
                end
                S_F_LO: begin
                    r_state <= S_F_CAP;
                    r_hi    <= mem_rdata;
                    mem_en  <= 1'b0;
                end
                S_F_CAP: begin
                    r_state     <= S_IDLE;
                    fetch_data  <= {r_hi, mem_rdata};
                    fetch_valid <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed bench for chip8_mem_arbiter: a behavioural sync-read memory, request
// drivers, and a negedge monitor that checks grants and read data from queues.
module tb_chip8_mem_arbiter;
    import chip8_mem_pkg::*;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_req, ld_gnt;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          dat_req, dat_we, dat_gnt, dat_valid;
    logic [AW-1:0] dat_addr;
    logic [DW-1:0] dat_wdata, dat_rdata;
    logic          fetch_req, fetch_gnt, fetch_valid;
    logic [AW-1:0] fetch_addr;
    logic [15:0]   fetch_data;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    chip8_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_wdata    (ld_wdata),
        .ld_gnt      (ld_gnt),
        .dat_req     (dat_req),
        .dat_we      (dat_we),
        .dat_addr    (dat_addr),
        .dat_wdata   (dat_wdata),
        .dat_gnt     (dat_gnt),
        .dat_valid   (dat_valid),
        .dat_rdata   (dat_rdata),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_gnt   (fetch_gnt),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    logic [15:0]   exp_fetch_q[$];
    logic [DW-1:0] exp_dat_q[$];
    logic [1:0]    exp_gnt_q[$];
    logic [AW-1:0] addr_log[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int f_gnt_cyc = 0;
    int d_gnt_cyc = 0;
    int en_cnt  = 0;
    int rd_cnt  = 0;
    int fgnt_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return {13'd0, ld_gnt, dat_gnt, dat_valid, dat_rdata, fetch_gnt, fetch_valid,
                fetch_data, mem_en, mem_we, mem_addr, mem_wdata};
    endfunction

    // Monitor: every grant and every valid must match the next queued expectation.
    always @(negedge clk) begin
        logic [1:0] gid;
        if (!rst) begin
            if (mem_en) begin
                en_cnt++;
                addr_log.push_back(mem_addr);
                if (!mem_we) rd_cnt++;
            end
            if (fetch_gnt) fgnt_cnt++;
            if (ld_gnt || dat_gnt || fetch_gnt) begin
                gid = ld_gnt ? REQ_LD : (fetch_gnt ? REQ_FETCH : REQ_DAT);
                check("gnt_onehot", int'(ld_gnt) + int'(dat_gnt) + int'(fetch_gnt), 1);
                if (exp_gnt_q.size() == 0) check("gnt_unexpected", gid, 2'd3);
                else                       check("gnt_order", gid, exp_gnt_q.pop_front());
                if (fetch_gnt) f_gnt_cyc = cyc;
                if (dat_gnt)   d_gnt_cyc = cyc;
            end
            if (fetch_valid) begin
                check("fetch_gnt_valid_excl", fetch_gnt, 0);
                if (exp_fetch_q.size() == 0) check("fetch_valid_unexpected", fetch_data, 64'hDEAD_0000);
                else                         check("fetch_data", fetch_data, exp_fetch_q.pop_front());
                check("fetch_latency", cyc - f_gnt_cyc, 3);
            end
            if (dat_valid) begin
                check("dat_gnt_valid_excl", dat_gnt, 0);
                if (exp_dat_q.size() == 0) check("dat_valid_unexpected", dat_rdata, 64'hDEAD_0000);
                else                       check("dat_rdata", dat_rdata, exp_dat_q.pop_front());
                check("dat_read_latency", cyc - d_gnt_cyc, 2);
            end
        end
    end

    task automatic drive_ld(input logic [AW-1:0] a, input logic [DW-1:0] d, output int waited);
        @(negedge clk);
        ld_addr = a; ld_wdata = d; ld_req = 1'b1; waited = 0;
        do begin @(negedge clk); waited++; end while (!ld_gnt && waited < 50);
        if (!ld_gnt) check("ld_gnt_timeout", ld_gnt, 1);
        ld_req = 1'b0;
    endtask

    task automatic drive_dat(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             output int waited);
        @(negedge clk);
        dat_we = we; dat_addr = a; dat_wdata = d; dat_req = 1'b1; waited = 0;
        do begin @(negedge clk); waited++; end while (!dat_gnt && waited < 50);
        if (!dat_gnt) check("dat_gnt_timeout", dat_gnt, 1);
        dat_req = 1'b0;
    endtask

    task automatic drive_fetch(input logic [AW-1:0] a, output int waited);
        @(negedge clk);
        fetch_addr = a; fetch_req = 1'b1; waited = 0;
        do begin @(negedge clk); waited++; end while (!fetch_gnt && waited < 50);
        if (!fetch_gnt) check("fetch_gnt_timeout", fetch_gnt, 1);
        fetch_req = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_fetch_q.size() + exp_dat_q.size() + exp_gnt_q.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, exp_fetch_q.size() + exp_dat_q.size() + exp_gnt_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w1, w2, w3, e0, r0, g0;
        rst = 1'b1;
        ld_req = 0; ld_addr = '0; ld_wdata = '0;
        dat_req = 0; dat_we = 0; dat_addr = '0; dat_wdata = '0;
        fetch_req = 0; fetch_addr = '0;

        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 0);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", all_outputs(), 0);

        // ROM image via the loader port
        exp_gnt_q.push_back(REQ_LD); drive_ld(12'h200, 8'h12, w);
        check("ld_gnt_latency", w, 1);
        exp_gnt_q.push_back(REQ_LD); drive_ld(12'h201, 8'h34, w);
        exp_gnt_q.push_back(REQ_LD); drive_ld(12'hFFF, 8'hAB, w);
        exp_gnt_q.push_back(REQ_LD); drive_ld(12'h000, 8'hCD, w);
        drain("load");
        check("mem_200_loaded", mem[12'h200], 8'h12);

        // Fetch at 0x200
        addr_log.delete(); e0 = en_cnt;
        exp_gnt_q.push_back(REQ_FETCH); exp_fetch_q.push_back(16'h1234);
        drive_fetch(12'h200, w);
        check("fetch_gnt_latency", w, 1);
        drain("fetch200");
        check("fetch200_mem_en_cycles", en_cnt - e0, 2);
        check("fetch200_addr_hi", addr_log.size() >= 1 ? addr_log[0] : 12'hEEE, 12'h200);
        check("fetch200_addr_lo", addr_log.size() >= 2 ? addr_log[1] : 12'hEEE, 12'h201);

        // Fetch at the top of memory wraps the low byte address
        addr_log.delete(); e0 = en_cnt;
        exp_gnt_q.push_back(REQ_FETCH); exp_fetch_q.push_back(16'hABCD);
        drive_fetch(12'hFFF, w);
        drain("fetchfff");
        check("fetchfff_mem_en_cycles", en_cnt - e0, 2);
        check("fetchfff_addr_wrap", addr_log.size() >= 2 ? addr_log[1] : 12'hEEE, 12'h000);

        // Data write then read back
        exp_gnt_q.push_back(REQ_DAT); drive_dat(1'b1, 12'h300, 8'h5A, w);
        check("dat_wr_gnt_latency", w, 1);
        drain("datwr");
        check("mem_300_written", mem[12'h300], 8'h5A);
        exp_gnt_q.push_back(REQ_DAT); exp_dat_q.push_back(8'h5A);
        drive_dat(1'b0, 12'h300, 8'h00, w);
        drain("datrd");

        // Loader write then data read of the same byte
        exp_gnt_q.push_back(REQ_LD); drive_ld(12'h400, 8'h77, w);
        exp_gnt_q.push_back(REQ_DAT); exp_dat_q.push_back(8'h77);
        drive_dat(1'b0, 12'h400, 8'h00, w);
        drain("ldread");

        // One-cycle fetch pulse while a loader write is in flight is never serviced
        r0 = rd_cnt; g0 = fgnt_cnt;
        exp_gnt_q.push_back(REQ_LD); drive_ld(12'h401, 8'h88, w);
        fetch_addr = 12'h200; fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        repeat (6) @(negedge clk);
        check("pulse_no_fetch_gnt", fgnt_cnt - g0, 0);
        check("pulse_no_mem_read", rd_cnt - r0, 0);
        drain("pulse");

        // Three-way contention from reset: ld, then fetch/data alternating
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        exp_gnt_q.push_back(REQ_LD);
        for (int i = 0; i < 3; i++) begin
            exp_gnt_q.push_back(REQ_FETCH);
            exp_gnt_q.push_back(REQ_DAT);
            exp_fetch_q.push_back(16'h1234);
            exp_dat_q.push_back(8'h5A);
        end
        fork
            drive_ld(12'h402, 8'h99, w1);
            for (int i = 0; i < 3; i++) drive_fetch(12'h200, w2);
            for (int i = 0; i < 3; i++) drive_dat(1'b0, 12'h300, 8'h00, w3);
        join
        drain("contend");

        // Reset during F_LO abandons the fetch
        exp_gnt_q.push_back(REQ_FETCH);
        drive_fetch(12'h200, w);
        @(posedge clk); #2 rst = 1'b1;
        #1 check("rst_async_outputs", all_outputs(), 0);
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rst = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_abort_queues_empty", exp_fetch_q.size() + exp_gnt_q.size(), 0);
        exp_gnt_q.push_back(REQ_FETCH); exp_fetch_q.push_back(16'h1234);
        drive_fetch(12'h200, w);
        check("post_rst_fetch_gnt_latency", w, 1);
        drain("postrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/chip8_mem_arbiter.md
# chip8_mem_arbiter

Shares the single-port 4096×8 CHIP-8 memory between three requesters:
- the CPU instruction fetch, which needs a 16-bit opcode from two consecutive bytes;
- the CPU data port (I-relative loads/stores for BCD and register save/restore);
- the program loader, which writes the ROM image.

The block sits between the `Hertz` core and `memory`. It sequences every memory access through one FSM, so no two requesters ever drive the memory in the same cycle.

## Interface
Parameters:
- ADDR_W, 12, byte address width; memory depth is 2^ADDR_W
- DATA_W, 8, memory word width

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- ld_req  in  1  loader write request; hold until ld_gnt
- ld_addr  in  ADDR_W  loader byte address
- ld_wdata  in  DATA_W  loader write byte
- ld_gnt  out  1  one-cycle pulse: loader write issued
- dat_req  in  1  CPU data request; hold until dat_gnt
- dat_we  in  1  1 = write, 0 = read
- dat_addr  in  ADDR_W  data byte address
- dat_wdata  in  DATA_W  data write byte
- dat_gnt  out  1  one-cycle pulse: data access issued
- dat_valid  out  1  one-cycle pulse: dat_rdata valid (reads only)
- dat_rdata  out  DATA_W  read byte
- fetch_req  in  1  opcode fetch request; hold until fetch_gnt
- fetch_addr  in  ADDR_W  address of the opcode high byte
- fetch_gnt  out  1  one-cycle pulse: fetch accepted
- fetch_valid  out  1  one-cycle pulse: fetch_data valid
- fetch_data  out  16  {mem[A], mem[A+1]}, big-endian
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  synchronous read data; valid the cycle after mem_en && !mem_we

## Operation
- States: IDLE, LD_WR, D_WR, D_RD, D_CAP, F_HI, F_LO, F_CAP.
- Requests are sampled only in IDLE. A request dropped before its gnt is never serviced.
- Priority among requesters:
  - the loader always wins;
  - fetch and data alternate round-robin through a `last` bit, updated on each fetch or data grant;
  - `last` resets to "data", so fetch wins the first tie.
- On acceptance in cycle N, the block:
  - latches the address and wdata;
  - enters the target state at N+1;
  - asserts the matching *_gnt at N+1, registered.
- LD_WR and D_WR:
  - memory write is issued at N+1;
  - the FSM returns to IDLE at N+2.
- Data read path, D_RD → D_CAP → IDLE:
  - read is issued at N+1;
  - mem_rdata is captured at N+2;
  - dat_valid is asserted at N+3.
- Fetch path, F_HI → F_LO → F_CAP → IDLE:
  - F_HI issues address A;
  - F_LO issues A+1 and captures the high byte;
  - F_CAP captures the low byte;
  - fetch_valid/fetch_data are registered at N+4.
- Address arithmetic: A+1 is modulo 2^ADDR_W, so 0xFFF wraps to 0x000. Odd A is legal.
- mem_en is asserted only in LD_WR, D_WR, D_RD, F_HI and F_LO. mem_we is asserted only in LD_WR and D_WR.
- When mem_en is 0, mem_addr and mem_wdata hold their last values.

## Timing
- Reset values: FSM=IDLE, last=data. Every output port resets to 0, including fetch_data, dat_rdata and mem_addr.
- Reset mid-transaction:
  - the access is abandoned immediately;
  - no gnt or valid follows;
  - a partially assembled opcode is discarded.
- Latency from request sampled in IDLE:
  - write gnt: 1 cycle;
  - data read valid: 3 cycles;
  - fetch valid: 4 cycles.
- Occupancy: write 2 cycles, data read 3 cycles, fetch 4 cycles. Back-to-back grants are therefore spaced 2/3/4 cycles apart.
- All outputs are registered. No combinational path exists from any *_req to any output.
- *_valid and *_gnt never assert in the same cycle for the same requester.

## Structure
- Package chip8_mem_pkg holds:
  - the state enum;
  - ADDR_W and DATA_W defaults;
  - requester ID constants (REQ_LD, REQ_DAT, REQ_FETCH).
- One sub-module, chip8_rr_pick:
  - two-way round-robin with a fixed-priority override input;
  - outputs a one-hot winner and an updated `last` bit;
  - purely combinational plus the `last` flop.
- The top level holds the FSM, the address/data latches and the opcode assembly registers.

## Test plan
- Memory preloaded with mem[0x200]=0x12, mem[0x201]=0x34. Fetch at 0x200 → fetch_gnt at N+1, fetch_valid with fetch_data=0x1234 at N+4, exactly two mem_en cycles.
- mem[0xFFF]=0xAB, mem[0x000]=0xCD. Fetch at 0xFFF → fetch_data=0xABCD, second mem_addr=0x000.
- Loader, data and fetch all request in the same cycle, held:
  - grant order is ld, fetch, data;
  - with fetch and data re-requesting continuously, grants alternate fetch/data.
- Data write 0x5A to 0x300, then data read of 0x300 → dat_valid with dat_rdata=0x5A exactly 3 cycles after the read is sampled.
- rst asserted during F_LO:
  - all outputs go to 0 asynchronously;
  - no fetch_valid is seen;
  - the next fetch after release completes normally.
- fetch_req pulsed for one cycle while the arbiter is busy with a loader write → no fetch_gnt and no memory read.
